// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered ALU with valid/ready input handshake.
//
// Single-cycle ops (AND, ADD, SUB, OR, XOR, NAND, NOR) load their result and
// flags on the accept edge, so they issue back to back at one op per cycle.
// MUL is an unsigned shift-add that takes WIDTH iterations. The unit drops
// in_ready for the whole multiply, which stalls the issuer.
//
// Parameters:
//   WIDTH      operand/result width, 4..32
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   in_valid   operands/opcode presented this cycle
//   in_ready   unit can accept (high iff FSM is IDLE)
//   A, B       operands (unsigned; A/B msb used as sign for overflow only)
//   opcode     000 AND, 001 ADD, 010 MUL, 011 SUB, 100 OR, 101 XOR,
//              110 NAND, 111 NOR
//   result     result (MUL: low half of the product)
//   result_hi  MUL high half; 0 for all other ops
//   carry_out  ADD carry / SUB borrow; 0 otherwise
//   overflow   signed overflow (ADD/SUB); MUL: result_hi != 0; 0 for logic
//   zero       result (and result_hi) all zero
//   out_valid  one-cycle pulse: outputs updated this cycle
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_NAND = 3'b110;
  localparam logic [2:0] OP_NOR  = 3'b111;

  // Iteration counter only needs to reach WIDTH-1.
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      cnt_reg;

  logic               accept;
  logic               last_iter;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_sum;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;

  assign in_ready  = (state_reg == IDLE);
  assign accept    = in_valid && in_ready;
  assign last_iter = (state_reg == MUL_BUSY) && (cnt_reg == CW'(WIDTH - 1));

  // One shift-add step. On the final step acc_sum is the finished product,
  // so the outputs are loaded straight from it on the same edge.
  assign partial = mplier_reg[cnt_reg] ? (mcand_reg << cnt_reg) : '0;
  assign acc_sum = acc_reg + partial;

  // Both computed WIDTH+1 wide. The top bit is the carry for ADD. For SUB
  // it is the borrow, which is set exactly when A < B (unsigned).
  assign add_sum  = {1'b0, A} + {1'b0, B};
  assign sub_diff = {1'b0, A} - {1'b0, B};

  // Single-cycle datapath
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (opcode)
      OP_AND:  alu_res = A & B;
      OP_ADD: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
        alu_ovf   = (A[WIDTH-1] == B[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = sub_diff[WIDTH-1:0];
        alu_carry = sub_diff[WIDTH];
        alu_ovf   = (A[WIDTH-1] != B[WIDTH-1]) &&
                    (sub_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NAND: alu_res = ~(A & B);
      OP_NOR:  alu_res = ~(A | B);
      default: alu_res = '0;  // MUL takes the multi-cycle path instead
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && (opcode == OP_MUL)) begin
          state_next = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (last_iter) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Multiplier operands, accumulator and iteration counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (accept && (opcode == OP_MUL)) begin
      mcand_reg  <= {{WIDTH{1'b0}}, A};
      mplier_reg <= B;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (state_reg == MUL_BUSY) begin
      acc_reg <= acc_sum;
      cnt_reg <= last_iter ? '0 : cnt_reg + 1'b1;
    end
  end

  // Output registers. They hold their values between operations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result    <= '0;
      result_hi <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && (opcode != OP_MUL)) begin
        result    <= alu_res;
        result_hi <= '0;
        carry_out <= alu_carry;
        overflow  <= alu_ovf;
        zero      <= (alu_res == '0);
        out_valid <= 1'b1;
      end else if (last_iter) begin
        result    <= acc_sum[WIDTH-1:0];
        result_hi <= acc_sum[2*WIDTH-1:WIDTH];
        carry_out <= 1'b0;
        overflow  <= |acc_sum[2*WIDTH-1:WIDTH];
        zero      <= (acc_sum == '0);
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered arithmetic/logic unit: the next-generation ALU for the datapath. It adds a configurable operand width, the full 3-bit opcode map, and status flags (carry, zero, overflow). It has a valid/ready input handshake and a multi-cycle shift-add multiplier, so the single-cycle ops issue back-to-back and MUL stalls the issuer.

## Interface
Parameters:
- WIDTH, 8, operand/result width; legal range 4..32.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode presented this cycle.
- in_ready  out  1  unit can accept; high iff FSM in IDLE.
- A  in  WIDTH  operand A (unsigned; treated as signed for overflow only).
- B  in  WIDTH  operand B.
- opcode  in  3  000 AND, 001 ADD, 010 MUL, 011 SUB, 100 OR, 101 XOR, 110 NAND, 111 NOR.
- result  out  WIDTH  result (MUL: low half of product).
- result_hi  out  WIDTH  MUL upper half; 0 for all other ops.
- carry_out  out  1  ADD carry / SUB borrow; 0 otherwise.
- overflow  out  1  signed overflow (ADD/SUB); MUL: result_hi != 0; 0 for logic ops.
- zero  out  1  result (and result_hi for MUL) all zero.
- out_valid  out  1  one-cycle pulse: outputs updated this cycle.

## Operation
- FSM states: IDLE, MUL_BUSY.
- Accept: a rising edge with in_valid && in_ready. A, B, and opcode are sampled only on an accept.
- Non-MUL op accepted in IDLE: result, flags, and result_hi=0 load on the same edge, and out_valid pulses for the following cycle. The FSM stays in IDLE.
- ADD: {carry_out, result} = A + B, computed at WIDTH+1 bits. overflow = (A[msb]==B[msb]) && (result[msb]!=A[msb]).
- SUB: result = A - B mod 2^WIDTH. carry_out = (A < B) unsigned borrow. overflow = (A[msb]!=B[msb]) && (result[msb]!=A[msb]).
- Logic ops: bitwise. carry_out = 0, overflow = 0.
- MUL is an unsigned shift-add:
  - The accept edge latches the multiplicand and multiplier, clears a 2*WIDTH accumulator, and enters MUL_BUSY with iteration counter = 0.
  - Each MUL_BUSY edge performs one iteration: if multiplier bit[counter] is set, add multiplicand << counter, then counter++.
  - On the edge completing iteration WIDTH-1: {result_hi, result} = product, carry_out = 0, overflow = |result_hi, zero = (product==0). out_valid pulses and the FSM returns to IDLE.
- During MUL_BUSY, in_valid is ignored (in_ready=0). result and flags hold the previous operation's values until MUL completes.
- Outputs hold their last values between operations. out_valid is 0 unless an operation just completed.
- Reset (rst low, any time, including mid-MUL): immediately drives FSM to IDLE and clears counter and accumulator. Outputs reset to: result=0, result_hi=0, carry_out=0, overflow=0, zero=0, out_valid=0. in_ready=1 once in IDLE. A partial MUL is discarded with no out_valid.

## Timing
- Single-cycle ops: accept at edge N, outputs and out_valid valid after edge N (latency 1). in_ready stays high, giving a throughput of 1 op/cycle.
- MUL: accept at edge N. in_ready=0 after edges N..N+WIDTH-1. Results and out_valid appear after edge N+WIDTH (latency WIDTH). in_ready is high again in the out_valid cycle, so the next op may be accepted at edge N+WIDTH+1.
- out_valid is exactly one cycle wide. There is no output backpressure; the consumer must capture on out_valid.
- Reset release: the first accept is possible on the first rising edge with rst high.

## Test plan
- WIDTH=8, ADD A=0xFF B=0x01 -> next cycle: result=0x00, carry_out=1, zero=1, overflow=0, out_valid=1 for one cycle.
- WIDTH=8, SUB A=0x80 B=0x01 -> result=0x7F, carry_out=0, overflow=1. Then SUB A=0x01 B=0x02 -> result=0xFF, carry_out=1, overflow=0.
- WIDTH=8, MUL A=0xFF B=0xFF -> in_ready low 8 cycles; exactly 8 cycles after accept: result_hi=0xFE, result=0x01, overflow=1, out_valid pulse. A second in_valid held during busy is not accepted until in_ready returns.
- Back-to-back: AND 0xF0&0x3C, XOR 0xF0^0x3C, NOR 0x00,0x00 on consecutive cycles -> out_valid on 3 consecutive cycles with 0x30, 0xCC, 0xFF.
- Reset mid-MUL: assert rst low 3 cycles after MUL accept -> all outputs 0 immediately, no out_valid. After release, ADD 0x02+0x03 -> 0x05.
- WIDTH=16, MUL A=0x1234 B=0x0010 -> after 16 cycles: result=0x2340, result_hi=0x0001, overflow=1.
